// File: rtl/audio_sample_pacer.sv
// audio_sample_pacer: assembles little-endian 16-bit stereo frames from a byte
// stream into a frame FIFO and releases one frame per sample period as
// offset-binary PWM duty words.
// Optional build macro AUDIO_PACER_MONO_MIX_EN: both duty outputs carry the
// average of the left and right channels instead of independent stereo.
module audio_sample_pacer #(
   parameter int unsigned CLK_HZ     = 100_000_000,
   parameter int unsigned SAMPLE_HZ  = 44_100,
   parameter int unsigned DUTY_W     = 10,
   parameter int unsigned FIFO_DEPTH = 256
) (
   input  logic                            CLK_100MHZ,
   input  logic                            rst_n,
   input  logic                            play,
   input  logic [7:0]                      in_data,
   input  logic                            in_valid,
   output logic                            in_ready,
   output logic [DUTY_W-1:0]               duty_l,
   output logic [DUTY_W-1:0]               duty_r,
   output logic                            sample_stb,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
   output logic                            underrun
);

   localparam int unsigned DIV = CLK_HZ / SAMPLE_HZ;
   localparam int unsigned CW  = $clog2(DIV);
   localparam int unsigned AW  = $clog2(FIFO_DEPTH);
   localparam int unsigned LW  = AW + 1;
   localparam logic [CW-1:0]     CNT_MAX = CW'(DIV - 1);
   localparam logic [DUTY_W-1:0] MID     = DUTY_W'(1 << (DUTY_W - 1));

   logic [1:0]        idx_q;
   logic [23:0]       hold_q;
   logic [31:0]       mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]     level_q, level_d;
   logic [CW-1:0]     count_q;
   logic [DUTY_W-1:0] duty_l_q, duty_r_q;
   logic [DUTY_W-1:0] conv_l, conv_r;
   logic              stb_q, underrun_q;
   logic              full, empty, accept, push, tick, pop;
   logic [31:0]       head;

   assign full   = (level_q == LW'(FIFO_DEPTH));
   assign empty  = (level_q == '0);
   // Only the final byte of a frame can be back-pressured; depends on state only.
   assign in_ready = (idx_q != 2'd3) || !full;
   assign accept = in_valid && in_ready;
   assign push   = accept && (idx_q == 2'd3);
   assign tick   = play && (count_q == CNT_MAX);
   assign pop    = tick && !empty;
   assign head   = mem[rd_ptr_q];

   assign duty_l     = duty_l_q;
   assign duty_r     = duty_r_q;
   assign sample_stb = stb_q;
   assign fifo_level = level_q;
   assign underrun   = underrun_q;

`ifdef AUDIO_PACER_MONO_MIX_EN
   // Average of both offset-binary channels; the 17-bit sum cannot overflow.
   function automatic logic [DUTY_W-1:0] mix_duty(input logic [15:0] l, input logic [15:0] r);
      logic [16:0] sum;
      sum = {1'b0, l ^ 16'h8000} + {1'b0, r ^ 16'h8000};
      return DUTY_W'(sum >> (17 - DUTY_W));
   endfunction

   // Convert the FIFO head into a shared mono duty word.
   always_comb begin
      conv_l = mix_duty(head[15:0], head[31:16]);
      conv_r = conv_l;
   end
`else
   // Signed sample to offset binary, keeping the top DUTY_W bits.
   function automatic logic [DUTY_W-1:0] to_duty(input logic [15:0] s);
      logic [15:0] u;
      u = s ^ 16'h8000;
      return DUTY_W'(u >> (16 - DUTY_W));
   endfunction

   // Convert the FIFO head into independent left/right duty words.
   always_comb begin
      conv_l = to_duty(head[15:0]);
      conv_r = to_duty(head[31:16]);
   end
`endif

   // Next fill level from simultaneous push/pop.
   always_comb begin
      level_d = level_q;
      if (push && !pop) begin
         level_d = level_q + LW'(1);
      end else if (pop && !push) begin
         level_d = level_q - LW'(1);
      end
   end

   // Frame assembly: byte index and holding register for the first three bytes.
   always_ff @(posedge CLK_100MHZ or negedge rst_n) begin
      if (!rst_n) begin
         idx_q  <= 2'd0;
         hold_q <= '0;
      end else if (accept) begin
         idx_q <= idx_q + 2'd1;
         if (idx_q != 2'd3) begin
            hold_q[idx_q*8 +: 8] <= in_data;
         end
      end
   end

   // Frame storage; contents need no reset since level/pointers qualify them.
   always_ff @(posedge CLK_100MHZ) begin
      if (push) begin
         mem[wr_ptr_q] <= {in_data, hold_q};
      end
   end

   // FIFO pointers and registered fill level.
   always_ff @(posedge CLK_100MHZ or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         level_q <= level_d;
      end
   end

   // Sample-period divider; parked at zero while paused.
   always_ff @(posedge CLK_100MHZ or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (!play || count_q == CNT_MAX) begin
         count_q <= '0;
      end else begin
         count_q <= count_q + CW'(1);
      end
   end

   // Duty outputs, strobe and sticky underrun, updated on the edge after a tick.
   always_ff @(posedge CLK_100MHZ or negedge rst_n) begin
      if (!rst_n) begin
         duty_l_q   <= MID;
         duty_r_q   <= MID;
         stb_q      <= 1'b0;
         underrun_q <= 1'b0;
      end else if (!play) begin
         duty_l_q   <= MID;
         duty_r_q   <= MID;
         stb_q      <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         stb_q <= tick;
         if (tick) begin
            if (empty) begin
               duty_l_q   <= MID;
               duty_r_q   <= MID;
               underrun_q <= 1'b1;
            end else begin
               duty_l_q <= conv_l;
               duty_r_q <= conv_r;
            end
         end
      end
   end

endmodule
